// File: rtl/fir_out_sink.sv
// FIR output receiver: decimate, rescale by arithmetic right shift, saturate, buffer in a FIFO.
// Define FIR_OUT_SINK_ROUND_EN to add round-half-up before the shift (default: floor truncation).
module fir_out_sink #(
   parameter int IN_W  = 32,
   parameter int OUT_W = 12,
   parameter int SHIFT = 8,
   parameter int DECIM = 1,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   input  logic signed [IN_W-1:0]   in_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic signed [OUT_W-1:0]  out_data,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     overflow,
   output logic [7:0]               sat_cnt,
   input  logic                     clr_flags
);

   localparam int AW = $clog2(DEPTH);
   localparam int DW = (DECIM > 1) ? $clog2(DECIM) : 1;
   localparam int RW = IN_W + 1;
   localparam logic signed [RW-1:0] MAXV = (RW'(1) << (OUT_W - 1)) - RW'(1);
   localparam logic signed [RW-1:0] MINV = ~MAXV;
`ifdef FIR_OUT_SINK_ROUND_EN
   localparam logic signed [RW-1:0] RND_OFS =
      (SHIFT > 0) ? (RW'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;
`endif

   function automatic logic signed [RW-1:0] scale(input logic signed [IN_W-1:0] x);
      logic signed [RW-1:0] r;
      r = {x[IN_W-1], x};
`ifdef FIR_OUT_SINK_ROUND_EN
      r = r + RND_OFS;
`endif
      return r >>> SHIFT;
   endfunction

   function automatic logic is_sat(input logic signed [RW-1:0] v);
      return (v > MAXV) || (v < MINV);
   endfunction

   function automatic logic signed [OUT_W-1:0] saturate(input logic signed [RW-1:0] v);
      logic signed [RW-1:0] c;
      c = v;
      if (v > MAXV) c = MAXV;
      else if (v < MINV) c = MINV;
      return c[OUT_W-1:0];
   endfunction

   logic [DW-1:0]            dcnt_q, dcnt_d;
   logic                     vld_p0_q, vld_p1_q;
   logic signed [IN_W-1:0]   smp_p0_q;
   logic signed [OUT_W-1:0]  smp_p1_q;
   logic signed [RW-1:0]     scl_p0;
   logic                     keep, sat_evt, ovf_evt;
   logic signed [OUT_W-1:0]  mem [DEPTH];
   logic [AW-1:0]            wr_q, wr_d, rd_q, rd_d;
   logic [AW:0]              cnt_q, cnt_d;
   logic signed [OUT_W-1:0]  head_q, head_d;
   logic                     ovf_q, ovf_d;
   logic [7:0]               sat_q, sat_d;
   logic                     full, push, pop;

   // Stage p0: decimation select
   assign keep = in_valid && (dcnt_q == '0);

   always_comb begin
      dcnt_d = dcnt_q;
      if (in_valid) dcnt_d = (dcnt_q == DW'(DECIM - 1)) ? '0 : dcnt_q + 1'b1;
   end

   // Stage p1: rescale and saturate
   assign scl_p0  = scale(smp_p0_q);
   assign sat_evt = vld_p0_q && is_sat(scl_p0);

   always_comb begin
      if (clr_flags) sat_d = sat_evt ? 8'd1 : 8'd0;
      else if (sat_evt && (sat_q != 8'hFF)) sat_d = sat_q + 8'd1;
      else sat_d = sat_q;
   end

   // Stage p2: FIFO push/pop; a full FIFO still accepts when the head leaves the same cycle
   assign full    = (cnt_q == (AW+1)'(DEPTH));
   assign pop     = out_valid && out_ready;
   assign push    = vld_p1_q && (!full || pop);
   assign ovf_evt = vld_p1_q && full && !pop;
   assign ovf_d   = ovf_evt || (ovf_q && !clr_flags);

   always_comb begin
      wr_d = wr_q + AW'(push);
      rd_d = rd_q + AW'(pop);
      unique case ({push, pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
      // Head register follows the next-state head; it freezes once the FIFO empties
      head_d = head_q;
      if (cnt_d != '0) head_d = (push && (wr_q == rd_d)) ? smp_p1_q : mem[rd_d];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         dcnt_q   <= '0;
         vld_p0_q <= 1'b0;
         vld_p1_q <= 1'b0;
         wr_q     <= '0;
         rd_q     <= '0;
         cnt_q    <= '0;
         head_q   <= '0;
         ovf_q    <= 1'b0;
         sat_q    <= '0;
      end else begin
         dcnt_q   <= dcnt_d;
         vld_p0_q <= keep;
         vld_p1_q <= vld_p0_q;
         wr_q     <= wr_d;
         rd_q     <= rd_d;
         cnt_q    <= cnt_d;
         head_q   <= head_d;
         ovf_q    <= ovf_d;
         sat_q    <= sat_d;
      end
   end

   always_ff @(posedge clk) begin
      if (keep) smp_p0_q <= in_data;
      smp_p1_q <= saturate(scl_p0);
      if (push) mem[wr_q] <= smp_p1_q;
   end

   assign out_valid = (cnt_q != '0);
   assign out_data  = head_q;
   assign level     = cnt_q;
   assign overflow  = ovf_q;
   assign sat_cnt   = sat_q;

endmodule

// File: tb/tb_fir_out_sink.sv
// Bench for fir_out_sink: vector table, directed corner sequences, and a randomized run
// against a queue-based reference model. Honors FIR_OUT_SINK_ROUND_EN for expectations.
module tb_fir_out_sink;
   localparam int SHIFT = 8;
   localparam int DEPTH = 8;

   logic                clk = 1'b0;
   logic                reset, in_valid, out_ready, clr_flags;
   logic signed [31:0]  in_data;
   logic                out_valid, overflow;
   logic signed [11:0]  out_data;
   logic [3:0]          level;
   logic [7:0]          sat_cnt;
   logic                d_out_valid, d_overflow;
   logic signed [11:0]  d_out_data;
   logic [3:0]          d_level;
   logic [7:0]          d_sat_cnt;

   fir_out_sink #(.IN_W(32), .OUT_W(12), .SHIFT(SHIFT), .DECIM(1), .DEPTH(DEPTH)) u_dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .level(level), .overflow(overflow), .sat_cnt(sat_cnt), .clr_flags(clr_flags));

   fir_out_sink #(.IN_W(32), .OUT_W(12), .SHIFT(SHIFT), .DECIM(3), .DEPTH(DEPTH)) u_dec (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
      .out_valid(d_out_valid), .out_ready(out_ready), .out_data(d_out_data),
      .level(d_level), .overflow(d_overflow), .sat_cnt(d_sat_cnt), .clr_flags(clr_flags));

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int nsat   = 0;

   task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; clr_flags = 1'b0;
      tick();
      reset = 1'b0;
   endtask

   // Reference: scale by 2^SHIFT with floor (optionally +half first), then clamp
   function automatic logic signed [11:0] ref_scale(input logic signed [31:0] x, output bit s);
      longint v, d, q;
      v = x;
      d = longint'(1) << SHIFT;
`ifdef FIR_OUT_SINK_ROUND_EN
      if (SHIFT > 0) v = v + d / 2;
`endif
      q = v / d;
      if ((v % d != 0) && (v < 0)) q = q - 1;
      s = 1'b1;
      if (q > 2047) return 12'sd2047;
      if (q < -2048) return -12'sd2048;
      s = 1'b0;
      return 12'(q);
   endfunction

   logic signed [11:0] mq[$];
   bit                 mv0, mv1, movf;
   logic signed [31:0] md0;
   logic signed [11:0] md1, mhead;
   int                 msat;

   task automatic model_step(input bit rst, input bit iv, input logic signed [31:0] id,
                             input bit ordy, input bit clr);
      bit pop, oset, sev;
      logic signed [11:0] sc;
      if (rst) begin
         mq.delete(); mv0 = 0; mv1 = 0; movf = 0; msat = 0; mhead = 0;
         return;
      end
      oset = 0; sev = 0; sc = 0;
      pop = (mq.size() > 0) && ordy;
      if (pop) void'(mq.pop_front());
      if (mv1) begin
         if (mq.size() < DEPTH) mq.push_back(md1);
         else oset = 1;
      end
      if (mv0) sc = ref_scale(md0, sev);
      mv1 = mv0; md1 = sc;
      mv0 = iv; md0 = id;
      if (mq.size() > 0) mhead = mq[0];
      if (oset) movf = 1;
      else if (clr) movf = 0;
      if (clr) msat = sev;
      else if (sev && msat < 255) msat++;
   endtask

   typedef struct {
      logic signed [31:0] din;
      int q_rnd;
      int q_trn;
      bit s_rnd;
      bit s_trn;
   } vec_t;
   vec_t tbl[11];

   initial begin
      #400000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1);
   end

   initial begin
      int k, j, e;
      bit s;
      bit r_rst, r_iv, r_rdy, r_clr;
      logic signed [31:0] r_d;

      tbl[0]  = '{32'sd384,         2,     1,     0, 0};
      tbl[1]  = '{-32'sd384,       -1,    -2,     0, 0};
      tbl[2]  = '{32'sh7FFFFFFF,    2047,  2047,  1, 1};
      tbl[3]  = '{32'sh80000000,   -2048, -2048,  1, 1};
      tbl[4]  = '{32'sd127,         0,     0,     0, 0};
      tbl[5]  = '{32'sd128,         1,     0,     0, 0};
      tbl[6]  = '{-32'sd129,       -1,    -1,     0, 0};
      tbl[7]  = '{-32'sd128,        0,    -1,     0, 0};
      tbl[8]  = '{32'sd524160,      2047,  2047,  1, 0};
      tbl[9]  = '{-32'sd524288,    -2048, -2048,  0, 0};
      tbl[10] = '{-32'sd524289,    -2048, -2048,  0, 1};

      in_data = '0;
      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; clr_flags = 1'b0;
      tick(); tick();
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_level", level, 0);
      chk("rst_overflow", overflow, 0);
      chk("rst_sat_cnt", sat_cnt, 0);
      reset = 1'b0;

      // Rounding/saturation vectors, one at a time, with latency checks
      foreach (tbl[i]) begin
`ifdef FIR_OUT_SINK_ROUND_EN
         e = tbl[i].q_rnd; s = tbl[i].s_rnd;
`else
         e = tbl[i].q_trn; s = tbl[i].s_trn;
`endif
         nsat += int'(s);
         in_valid = 1'b1; in_data = tbl[i].din;
         tick();
         in_valid = 1'b0;
         chk("lat_edge1_valid", out_valid, 0);
         tick();
         chk("lat_edge2_valid", out_valid, 0);
         tick();
         chk("vec_valid", out_valid, 1);
         chk("vec_data", out_data, e);
         chk("vec_level", level, 1);
         out_ready = 1'b1;
         tick();
         out_ready = 1'b0;
         chk("vec_pop_level", level, 0);
         chk("vec_hold_data", out_data, e);
      end
      chk("sat_cnt_total", sat_cnt, nsat);
      clr_flags = 1'b1;
      tick();
      clr_flags = 1'b0;
      chk("sat_cnt_cleared", sat_cnt, 0);

      // Overflow: 10 pushes into 8 entries, then drain in order
      do_reset();
      for (k = 1; k <= 10; k++) begin
         in_valid = 1'b1; in_data = 256 * k;
         tick();
      end
      in_valid = 1'b0;
      tick(); tick();
      chk("ovf_level", level, 8);
      chk("ovf_flag", overflow, 1);
      out_ready = 1'b1;
      for (k = 1; k <= 8; k++) begin
         chk("ovf_drain_data", out_data, k);
         tick();
      end
      out_ready = 1'b0;
      chk("ovf_empty_valid", out_valid, 0);
      chk("ovf_empty_hold", out_data, 8);
      chk("ovf_still_set", overflow, 1);
      clr_flags = 1'b1;
      tick();
      clr_flags = 1'b0;
      chk("ovf_cleared", overflow, 0);

      // Full FIFO with simultaneous pop under continuous input
      do_reset();
      k = 1;
      in_valid = 1'b1;
      repeat (10) begin
         in_data = 256 * k; k++;
         tick();
      end
      chk("full_level", level, 8);
      out_ready = 1'b1;
      for (j = 1; j <= 12; j++) begin
         chk("full_pop_data", out_data, j);
         in_data = 256 * k; k++;
         tick();
         chk("full_pop_level", level, 8);
         chk("full_pop_ovf", overflow, 0);
      end
      in_valid = 1'b0; out_ready = 1'b0;

      // Decimation by 3
      do_reset();
      for (k = 1; k <= 9; k++) begin
         in_valid = 1'b1; in_data = 256 * k;
         tick();
      end
      in_valid = 1'b0;
      tick(); tick();
      chk("dec_level", d_level, 3);
      chk("dec_ovf", d_overflow, 0);
      chk("dec_sat", d_sat_cnt, 0);
      out_ready = 1'b1;
      for (k = 1; k <= 7; k += 3) begin
         chk("dec_data", d_out_data, k);
         tick();
      end
      chk("dec_empty", d_out_valid, 0);
      out_ready = 1'b0;

      // Reset mid-stream with a sample in flight
      do_reset();
      for (k = 1; k <= 5; k++) begin
         in_valid = 1'b1; in_data = 256 * k;
         tick();
      end
      in_valid = 1'b0;
      tick(); tick();
      chk("mid_level_pre", level, 5);
      in_valid = 1'b1; in_data = 256 * 30; reset = 1'b1;
      tick();
      reset = 1'b0; in_valid = 1'b0;
      chk("mid_rst_level", level, 0);
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_data", out_data, 0);
      tick(); tick();
      chk("mid_inflight_gone", level, 0);
      in_valid = 1'b1; in_data = 256 * 20;
      tick();
      in_valid = 1'b0;
      tick(); tick();
      chk("mid_dec_kept_valid", d_out_valid, 1);
      chk("mid_dec_kept_data", d_out_data, 20);
      chk("mid_main_data", out_data, 20);

      // Randomized run against the reference model
      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; clr_flags = 1'b0;
      model_step(1, 0, 0, 0, 0);
      tick();
      for (int n = 0; n < 600; n++) begin
         r_rst = ($urandom_range(0, 199) == 0);
         r_iv  = ($urandom_range(0, 99) < 65);
         r_rdy = ($urandom_range(0, 99) < 55);
         r_clr = ($urandom_range(0, 39) == 0);
         if ($urandom_range(0, 3) == 0) r_d = $signed($urandom);
         else r_d = $signed($urandom) >>> $urandom_range(8, 22);
         reset = r_rst; in_valid = r_iv; in_data = r_d; out_ready = r_rdy; clr_flags = r_clr;
         model_step(r_rst, r_iv, r_d, r_rdy, r_clr);
         tick();
         chk("rnd_level", level, mq.size());
         chk("rnd_valid", out_valid, (mq.size() > 0));
         chk("rnd_data", out_data, mhead);
         chk("rnd_overflow", overflow, movf);
         chk("rnd_sat_cnt", sat_cnt, msat);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
